ps2_kbd_tx: RTL

//  PS/2 device-side keyboard transmitter: serialises host-supplied scan-code bytes into PS/2 clk/data frames.
//  It is the far end of the PS/2 receiver inside the machine core.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/byte_fifo.sv | 59 +++++
 rtl/ps2_kbd_tx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame size, scan-code
// constants and the odd-parity frame builder.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      GAP     = 2'd2,
      INHIBIT = 2'd3
   } ps2_tx_state_t;

   localparam int unsigned PS2_FRAME_BITS = 11;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   // Cell order, bit 0 first: start 0, d[0..7], parity, stop 1.
   function automatic logic [PS2_FRAME_BITS-1:0] make_frame(input logic [7:0] d);
      return {1'b1, odd_parity(d), d, 1'b0};
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Generic synchronous FIFO with registered occupancy count; DEPTH must be a
// power of two so the pointers wrap naturally.
module byte_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side keyboard transmitter: queues scan-code bytes and shifts
// them out as 11-cell clk/data frames, backing off while the host inhibits.
module ps2_kbd_tx #(
   parameter int unsigned CLK_HALF   = 1103,
   parameter int unsigned IDLE_GAP   = 2206,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       overflow,
   input  logic       ps2_clk_i,
   output logic       ps2_clk_o,
   output logic       ps2_dat_o,
   output logic       busy
);

   import ps2_pkg::*;

   localparam int unsigned CELL    = 2 * CLK_HALF;
   localparam int unsigned CNT_MAX = (CELL > IDLE_GAP) ? CELL : IDLE_GAP;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HALF_CNT  = CW'(CLK_HALF);
   localparam logic [CW-1:0] CELL_LAST = CW'(CELL - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(IDLE_GAP - 1);
   localparam logic [3:0]    STOP_IDX  = 4'(PS2_FRAME_BITS - 1);

   ps2_tx_state_t              state;
   logic [CW-1:0]              cnt;
   logic [3:0]                 bit_idx;
   logic [PS2_FRAME_BITS-1:0]  frame;

   logic [7:0]                 fifo_head;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                       fifo_pop;

   logic clk_high;
   logic cell_end;
   logic stop_cell;
   logic start_ok;
   logic gap_done;
   logic load;

   byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign clk_high  = (cnt < HALF_CNT);
   assign cell_end  = (cnt == CELL_LAST);
   assign stop_cell = (bit_idx == STOP_IDX);
   assign start_ok  = ~fifo_empty & ps2_clk_i;
   assign gap_done  = (state == GAP) && (cnt == GAP_LAST);
   assign load      = start_ok & ((state == IDLE) | gap_done);
   assign fifo_pop  = (state == SHIFT) & cell_end & stop_cell;

   // A queued byte leaves GAP straight into SHIFT so back-to-back frames are
   // separated by exactly IDLE_GAP high cycles.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         frame   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (start_ok) begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (~ps2_clk_i && clk_high && !stop_cell) begin
                  state <= INHIBIT;
                  cnt   <= '0;
               end else if (cell_end) begin
                  cnt <= '0;
                  if (stop_cell) begin
                     state <= GAP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_done) begin
                  cnt   <= '0;
                  state <= start_ok ? SHIFT : IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            INHIBIT: begin
               if (!ps2_clk_i) begin
                  cnt <= '0;
               end else if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
         if (load) begin
            frame   <= make_frame(fifo_head);
            bit_idx <= '0;
         end
      end
   end

   assign ps2_clk_o = (state != SHIFT) | clk_high;
   assign ps2_dat_o = (state != SHIFT) | frame[bit_idx];
   assign in_ready  = ~fifo_full;
   assign overflow  = in_valid & fifo_full;
   assign busy      = (state != IDLE) | (fifo_count != '0);

endmodule
